// File: rtl/barrel_shifter_pkg.sv
// Shared constants and helpers for the registered rotate unit.
package barrel_shifter_pkg;

    localparam int unsigned BS_DEFAULT_WIDTH = 4;
    localparam int unsigned BS_MAX_WIDTH     = 64;

    // Width of the rotate amount for a given operand width.
    function automatic int unsigned bs_shw(input int unsigned width);
        return int'($clog2(width));
    endfunction

    // Left-rotate of the low 'width' bits of value by amount.
    function automatic logic [BS_MAX_WIDTH-1:0] rotl(
        input logic [BS_MAX_WIDTH-1:0] value,
        input int unsigned             amount,
        input int unsigned             width
    );
        logic [BS_MAX_WIDTH-1:0] res;
        res = '0;
        for (int unsigned i = 0; i < width; i++) begin
            res[i] = value[(i + width - (amount % width)) % width];
        end
        return res;
    endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One mux stage of the rotate cascade: rotates by DIST when en_i is set.
// Direction input exists only when BARREL_SHIFTER_DIR_EN is defined.
module barrel_shift_stage #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DIST  = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             en_i,
`ifdef BARREL_SHIFTER_DIR_EN
    input  logic             dir_i,
`endif
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] rotl_w;
    logic [WIDTH-1:0] rotr_w;

    assign rotl_w = (data_i << DIST) | (data_i >> (WIDTH - DIST));
    assign rotr_w = (data_i >> DIST) | (data_i << (WIDTH - DIST));

    always_comb begin
        data_o = data_i;
        if (en_i) begin
`ifdef BARREL_SHIFTER_DIR_EN
            data_o = dir_i ? rotr_w : rotl_w;
`else
            data_o = rotl_w;
`endif
        end
    end

`ifndef BARREL_SHIFTER_DIR_EN
    logic unused_rotr;
    assign unused_rotr = ^rotr_w;
`endif

endmodule

// File: rtl/barrel_shifter.sv
// Registered barrel rotator: log2(WIDTH) mux stages feeding one output register.
// Optional right-rotate via dir port when BARREL_SHIFTER_DIR_EN is defined.
module barrel_shifter
    import barrel_shifter_pkg::*;
#(
    parameter int unsigned WIDTH = BS_DEFAULT_WIDTH,
    parameter int unsigned SHW   = bs_shw(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   sel,
`ifdef BARREL_SHIFTER_DIR_EN
    input  logic             dir,
`endif
    output logic [WIDTH-1:0] shift_out
);

    logic [WIDTH-1:0] stage_w [SHW+1];
    logic [WIDTH-1:0] shift_out_d;
    logic [WIDTH-1:0] shift_out_q;

    assign stage_w[0] = a;

    // Stage k rotates by 2^k under sel[k].
    for (genvar k = 0; k < int'(SHW); k++) begin : g_stage
        barrel_shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (32'(1) << k)
        ) u_stage (
            .data_i (stage_w[k]),
            .en_i   (sel[k]),
`ifdef BARREL_SHIFTER_DIR_EN
            .dir_i  (dir),
`endif
            .data_o (stage_w[k+1])
        );
    end

    assign shift_out_d = stage_w[SHW];

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_out_q <= '0;
        end else begin
            shift_out_q <= shift_out_d;
        end
    end

    assign shift_out = shift_out_q;

endmodule

// File: tb/tb_barrel_shifter.sv
// Bench for barrel_shifter: directed vector table, exhaustive sweep, random traffic.
module tb_barrel_shifter;

    localparam int unsigned W = 4;

    typedef struct {
        logic         rst;
        logic [W-1:0] a;
        logic [1:0]   sel;
        logic         dir;
        logic [W-1:0] exp;
        string        name;
    } vec_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [1:0]   sel;
    logic         dir;
    logic [W-1:0] shift_out;

    int total;
    int bad;
    vec_t vecs[$];

    barrel_shifter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .sel       (sel),
`ifdef BARREL_SHIFTER_DIR_EN
        .dir       (dir),
`endif
        .shift_out (shift_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: output bit i takes a[(i - s) mod W] for left, a[(i + s) mod W] for right.
    function automatic logic [W-1:0] model(input logic [W-1:0] av, input int s, input logic d);
        logic [W-1:0] r;
        int idx;
        r = '0;
        for (int i = 0; i < int'(W); i++) begin
            if (d) idx = (i + s) % int'(W);
            else   idx = (i - s + int'(W)) % int'(W);
            r[i] = av[idx];
        end
        return r;
    endfunction

    task automatic add_vec(input logic r, input logic [W-1:0] av, input logic [1:0] s,
                           input logic d, input logic [W-1:0] e, input string n);
        vec_t v;
        v.rst = r; v.a = av; v.sel = s; v.dir = d; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    task automatic check(input string n, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b", n, got, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it in, sample just after the edge.
    task automatic step(input logic r, input logic [W-1:0] av, input logic [1:0] s, input logic d);
        rst = r; a = av; sel = s; dir = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; a = '0; sel = '0; dir = 1'b0;

        add_vec(1, 4'b1111, 2'b01, 0, 4'b0000, "rst_hold0");
        add_vec(1, 4'b1111, 2'b01, 0, 4'b0000, "rst_hold1");
        add_vec(0, 4'b1111, 2'b01, 0, 4'b1111, "rst_release");
        add_vec(0, 4'b1110, 2'b00, 0, 4'b1110, "e_sel0");
        add_vec(0, 4'b1110, 2'b01, 0, 4'b1101, "e_sel1");
        add_vec(0, 4'b1110, 2'b10, 0, 4'b1011, "e_sel2");
        add_vec(0, 4'b1110, 2'b11, 0, 4'b0111, "e_sel3");
        add_vec(0, 4'b0111, 2'b00, 0, 4'b0111, "7_sel0");
        add_vec(0, 4'b0111, 2'b01, 0, 4'b1110, "7_sel1");
        add_vec(0, 4'b0111, 2'b10, 0, 4'b1101, "7_sel2");
        add_vec(0, 4'b0111, 2'b11, 0, 4'b1011, "7_sel3");
        add_vec(0, 4'b1000, 2'b10, 0, 4'b0010, "pre_mid");
        add_vec(1, 4'b1000, 2'b01, 0, 4'b0000, "mid_rst");
        add_vec(0, 4'b1000, 2'b01, 0, 4'b0001, "mid_release");
`ifdef BARREL_SHIFTER_DIR_EN
        add_vec(0, 4'b1110, 2'b01, 1, 4'b0111, "dir_r1");
        add_vec(0, 4'b1110, 2'b11, 1, 4'b1101, "dir_r3");
        add_vec(0, 4'b1110, 2'b01, 0, 4'b1101, "dir_l1");
`endif

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].a, vecs[i].sel, vecs[i].dir);
            check(vecs[i].name, shift_out, vecs[i].exp);
        end

        // Exhaustive back-to-back sweep, one result per cycle.
        for (int av = 0; av < 16; av++) begin
            for (int s = 0; s < 4; s++) begin
                step(1'b0, W'(av), 2'(s), 1'b0);
                check($sformatf("sweep_a%0d_s%0d", av, s), shift_out, model(W'(av), s, 1'b0));
            end
        end

        // Random traffic with occasional resets.
        for (int n = 0; n < 300; n++) begin
            logic         r;
            logic [W-1:0] av;
            logic [1:0]   s;
            logic         d;
            logic [W-1:0] e;
            r  = ($urandom_range(0, 9) == 0);
            av = W'($urandom);
            s  = 2'($urandom);
`ifdef BARREL_SHIFTER_DIR_EN
            d  = 1'($urandom);
`else
            d  = 1'b0;
`endif
            e  = r ? '0 : model(av, int'(s), d);
            step(r, av, s, d);
            check($sformatf("rand%0d", n), shift_out, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
